// File: rtl/trng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trng_pkg
// Description : Shared word width, word-pair type and saturating increment
//               used across the TRNG IP.
// Revision    : 1.0 - initial release
// ============================================================================
package trng_pkg;

    localparam int TRNG_WORD_W = 32;

    typedef struct packed {
        logic [TRNG_WORD_W-1:0] raw;
        logic [TRNG_WORD_W-1:0] range;
    } trng_pair_t;

    // Counters up to 32 bits wide share this; callers zero-extend and truncate.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/trng_fwft_fifo.sv
`default_nettype none
// ============================================================================
// Module      : trng_fwft_fifo
// Description : First-word-fall-through register FIFO with explicit level
//               counter and a synchronous flush that outranks push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_fwft_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             valid,
    output logic             full,
    output logic [AW:0]      level
);

    localparam logic [AW:0]   c_full_level = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_level_one  = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one    = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_full_level);

    // A pop on an empty FIFO is ignored; a push into a full FIFO needs a pop.
    assign w_pop  = pop & ~w_empty;
    assign w_push = push & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_level_one;
                2'b01:   r_level <= r_level - c_level_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_push && !flush && !reset) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign valid   = ~w_empty;
    assign full    = w_full;
    assign level   = r_level;

endmodule
`default_nettype wire

// File: rtl/trng_word_buffer.sv
`default_nettype none
// ============================================================================
// Module      : trng_word_buffer
// Description : Buffers TRNG word pairs for the read path, rejecting repeated
//               words and flushing on health loss or duplicate alarm.
// Revision    : 1.0 - initial release
// ============================================================================
module trng_word_buffer
    import trng_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int CNT_W = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [TRNG_WORD_W-1:0] in_raw,
    input  logic [TRNG_WORD_W-1:0] in_range,
    input  logic                   in_health_ok,
    input  logic                   flush,
    input  logic                   clr_alarms,
    input  logic                   rd_en,
    output logic                   out_valid,
    output logic [TRNG_WORD_W-1:0] out_raw,
    output logic [TRNG_WORD_W-1:0] out_range,
    output logic [AW:0]            level,
    output logic                   full,
    output logic                   dup_fail,
    output logic [CNT_W-1:0]       ovf_cnt,
    output logic [CNT_W-1:0]       dup_cnt
);

    logic [TRNG_WORD_W-1:0] r_last_raw;
    logic                   r_have_last;
    logic                   r_health_q;
    logic                   r_dup_fail;
    logic [CNT_W-1:0]       r_ovf_cnt;
    logic [CNT_W-1:0]       r_dup_cnt;

    logic                   w_fifo_valid;
    logic                   w_fifo_full;
    logic                   w_pop;
    logic                   w_live;
    logic                   w_dup;
    logic                   w_ovf;
    logic                   w_accept;
    logic                   w_health_fall;
    logic                   w_flush;
    trng_pair_t             w_wr_pair;
    trng_pair_t             w_head;

    assign w_pop  = rd_en & w_fifo_valid;
    assign w_live = in_valid & in_health_ok;

    // Acceptance rules, in priority order: health, duplicate, overflow, push.
    assign w_dup    = w_live & r_have_last & (in_raw == r_last_raw);
    assign w_ovf    = w_live & ~w_dup & w_fifo_full & ~w_pop;
    assign w_accept = w_live & ~w_dup & ~w_ovf;

    assign w_health_fall = r_health_q & ~in_health_ok;
    assign w_flush       = flush | w_health_fall | w_dup;

    assign w_wr_pair.raw   = in_raw;
    assign w_wr_pair.range = in_range;

    trng_fwft_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(trng_pair_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (w_flush),
        .push    (w_accept),
        .pop     (w_pop),
        .wr_data (w_wr_pair),
        .rd_data (w_head),
        .valid   (w_fifo_valid),
        .full    (w_fifo_full),
        .level   (level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_raw  <= '0;
            r_have_last <= 1'b0;
            r_health_q  <= 1'b0;
            r_dup_fail  <= 1'b0;
            r_ovf_cnt   <= '0;
            r_dup_cnt   <= '0;
        end else begin
            r_health_q <= in_health_ok;
            // Overflowed words still count as "seen" for the duplicate test.
            if (w_accept || w_ovf) begin
                r_last_raw <= in_raw;
            end
            if (w_accept) begin
                r_have_last <= 1'b1;
            end
            if (w_dup) begin
                r_dup_fail <= 1'b1;
                r_dup_cnt  <= CNT_W'(sat_inc(32'(r_dup_cnt), CNT_W));
            end else if (clr_alarms) begin
                r_dup_fail <= 1'b0;
            end
            if (w_ovf) begin
                r_ovf_cnt <= CNT_W'(sat_inc(32'(r_ovf_cnt), CNT_W));
            end
        end
    end

    assign out_valid = w_fifo_valid;
    assign full      = w_fifo_full;
    assign out_raw   = w_head.raw;
    assign out_range = w_head.range;
    assign dup_fail  = r_dup_fail;
    assign ovf_cnt   = r_ovf_cnt;
    assign dup_cnt   = r_dup_cnt;

endmodule
`default_nettype wire

// File: doc/trng_word_buffer.md
Name: trng_word_buffer

Overview:
- Downstream stage of the TRNG core. Captures each 32-bit word pair (raw, in-range) strobed out by the core into a first-word-fall-through FIFO, then releases it to the AXI slave read path through a pop handshake.
- Applies a word-level continuous test that rejects a word identical to the previous accepted word.
- Flushes all buffered words whenever the upstream health status drops or the duplicate alarm fires, so stale entropy is never read out.

Parameters:
- DEPTH, 16, number of word-pair entries; power of two, 2..256.
- CNT_W, 16, width of the saturating drop counters.
- Localparam AW = clog2(DEPTH), the pointer width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  one-cycle strobe from the core; a fresh word pair is present
- in_raw  in  32  raw random word
- in_range  in  32  range-mapped random word
- in_health_ok  in  1  core health status; 1 = no alarms
- flush  in  1  software flush request, one cycle
- clr_alarms  in  1  clears dup_fail
- rd_en  in  1  pop request; honoured only when out_valid = 1
- out_valid  out  1  FIFO not empty; out_raw and out_range hold the head entry
- out_raw  out  32  head raw word
- out_range  out  32  head in-range word
- level  out  AW+1  number of stored entries, 0..DEPTH
- full  out  1  level == DEPTH
- dup_fail  out  1  sticky alarm: duplicate consecutive word detected
- ovf_cnt  out  CNT_W  words dropped because the FIFO was full; saturates at all-ones
- dup_cnt  out  CNT_W  words dropped by the duplicate test; saturates at all-ones

Behaviour:
- Reset (sync, active-high) values:
  - pointers = 0, level = 0, out_valid = 0, full = 0
  - dup_fail = 0, ovf_cnt = 0, dup_cnt = 0, have_last = 0
  - out_raw and out_range read the array head; the array itself is not reset.
- Storage is a register array of {in_raw, in_range}. The head is read combinationally at rd_ptr (FWFT).
- Word acceptance on in_valid, evaluated in this order:
  1. If in_health_ok = 0: drop the word; no counter changes.
  2. Else if have_last = 1 and in_raw == last_raw: drop the word, increment dup_cnt, set dup_fail.
  3. Else if the FIFO is full and no pop occurs this cycle: drop the word, increment ovf_cnt, update last_raw.
  4. Else: push the word, set last_raw = in_raw, set have_last = 1.
- Push latency: a word accepted at edge N makes out_valid = 1 from edge N onward (visible in cycle N+1).
- Pop:
  - rd_en with out_valid = 1 advances rd_ptr at the edge.
  - rd_en with out_valid = 0 is ignored; no underflow and no state change.
- Full with simultaneous push and pop: both happen; level stays DEPTH.
- Empty with simultaneous push and pop: pop ignored, push happens; level becomes 1.
- Pointers are AW bits and wrap modulo DEPTH. level is tracked explicitly as an up/down counter.
- Flush:
  - Triggered by flush = 1, by in_health_ok falling (registered 1→0 detect), or by dup_fail being set this cycle.
  - Effect: rd_ptr = wr_ptr = 0, level = 0, out_valid = 0 after the edge.
  - Flush has priority over a push or pop in the same cycle; a word arriving that cycle is discarded.
  - Flush does not clear have_last, last_raw, or the counters.
- Alarm clearing:
  - clr_alarms clears dup_fail.
  - If a duplicate is detected in the same cycle as clr_alarms, set wins.
  - ovf_cnt and dup_cnt clear only on reset.
- While dup_fail = 1: words continue to be accepted by the rules above. Software decides the policy through clr_alarms.
- The block holds no combinational path from inputs to out_valid or full.

Decomposition:
- Package trng_pkg:
  - TRNG_WORD_W = 32
  - typedef trng_pair_t = struct {raw, range}
  - the saturating-increment function, shared with other counters in the IP
- One sub-module, trng_fwft_fifo: generic storage, pointers, level, full/empty, and flush.
- trng_word_buffer wraps it with the acceptance rules, the duplicate test, the alarms, and the counters.

Test Plan:
- Reset, then 3 strobes with raw = 0x1, 0x2, 0x3 and health_ok = 1 → level = 3, out_raw = 0x1; three pops return 0x1, 0x2, 0x3; out_valid = 0 afterwards.
- Strobes with raw = 0xA5A5A5A5 twice in a row → second word dropped, dup_cnt = 1, dup_fail = 1, FIFO flushed (level = 0); clr_alarms → dup_fail = 0.
- DEPTH = 16: 17 distinct pushes with no pops → level = 16, full = 1, ovf_cnt = 1; push and pop in the same cycle while full → level stays 16, head advances.
- Fill to 5 entries, drop in_health_ok to 0 → level = 0 next cycle; strobes while low are ignored and counters are unchanged.
- flush asserted in the same cycle as in_valid and rd_en at level 4 → level = 0, the arriving word is not stored.
- rd_en held for 10 cycles while empty → level stays 0 and no pointer movement; force 0xFFFF dup events → dup_cnt saturates at 0xFFFF.
